// File: rtl/bicubic_channel_arbiter_if.sv
// Handshake bundle tying the colour-channel requesters, the bicubic upsample core
// and the downstream result consumer to the channel arbiter.
interface bicubic_channel_arbiter_if #(
    parameter int NCH           = 3,
    parameter int CHANNEL_WIDTH = 8
);
    logic [NCH-1:0]                  ch_req_valid;
    logic [NCH-1:0]                  ch_req_ready;
    logic [NCH*16*CHANNEL_WIDTH-1:0] ch_req_pixels;
    logic                            arb_req_valid;
    logic                            core_req_ready;
    logic [16*CHANNEL_WIDTH-1:0]     arb_pixels;
    logic                            core_rsp_valid;
    logic [8*CHANNEL_WIDTH-1:0]      core_rsp_data;
    logic                            arb_rsp_ready;
    logic                            arb_rsp_valid;
    logic [8*CHANNEL_WIDTH-1:0]      arb_rsp_data;
    logic [1:0]                      arb_rsp_ch;
    logic                            arb_rsp_phase;
    logic                            dn_rsp_ready;
    logic [15:0]                     win_cnt;

    // Environment side: channel requesters, core and downstream consumer.
    modport master (
        output ch_req_valid, ch_req_pixels, core_req_ready, core_rsp_valid,
               core_rsp_data, dn_rsp_ready,
        input  ch_req_ready, arb_req_valid, arb_pixels, arb_rsp_ready,
               arb_rsp_valid, arb_rsp_data, arb_rsp_ch, arb_rsp_phase, win_cnt
    );

    // Arbiter side.
    modport slave (
        input  ch_req_valid, ch_req_pixels, core_req_ready, core_rsp_valid,
               core_rsp_data, dn_rsp_ready,
        output ch_req_ready, arb_req_valid, arb_pixels, arb_rsp_ready,
               arb_rsp_valid, arb_rsp_data, arb_rsp_ch, arb_rsp_phase, win_cnt
    );
endinterface

// File: rtl/bicubic_channel_arbiter.sv
// Round-robin arbiter feeding one 4x4 pixel window at a time from NCH colour channels
// into a shared bicubic core and tagging the two result beats with the owning channel.
module bicubic_channel_arbiter #(
    parameter int NCH           = 3,
    parameter int CHANNEL_WIDTH = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    bicubic_channel_arbiter_if.slave bus
);
    localparam int WIN_W = 16 * CHANNEL_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PH0  = 2'd1,
        ST_PH1  = 2'd2
    } state_t;

    state_t             state_r;
    logic [1:0]         rr_ptr_r;
    logic [1:0]         grant_ch_r;
    logic [WIN_W-1:0]   win_r;
    logic [15:0]        win_cnt_r;
    logic               busy_r;
    logic               phase_r;

    logic               grant_hit_s;
    logic [1:0]         grant_idx_s;
    logic [WIN_W-1:0]   grant_pix_s;
    logic [NCH-1:0]     ch_req_ready_s;
    logic               ph0_done_s;
    logic               ph1_done_s;
    logic [1:0]         rr_next_s;

    // Returns {hit, index} of the first valid channel at or after ptr, wrapping at NCH.
    function automatic logic [2:0] pick_channel(input logic [NCH-1:0] valid,
                                                input logic [1:0]     ptr);
        logic [2:0] res;
        logic [2:0] cand;
        res = 3'b000;
        // Farthest offset first, so the nearest requester overwrites and wins.
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + 3'(i);
            if (cand >= 3'(NCH)) begin
                cand = cand - 3'(NCH);
            end else begin
                cand = cand;
            end
            if (valid[cand[1:0]]) begin
                res = {1'b1, cand[1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Round-robin grant candidate for the current IDLE cycle.
    always_comb begin
        {grant_hit_s, grant_idx_s} = pick_channel(bus.ch_req_valid, rr_ptr_r);
    end

    // Window slice of the granted channel only.
    always_comb begin
        grant_pix_s = {WIN_W{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            if (grant_idx_s == 2'(k)) begin
                grant_pix_s = bus.ch_req_pixels[k*WIN_W +: WIN_W];
            end else begin
                grant_pix_s = grant_pix_s;
            end
        end
    end

    // One-hot accept pulse in IDLE; forced low while reset is asserted.
    always_comb begin
        ch_req_ready_s = {NCH{1'b0}};
        if (rst_n && (state_r == ST_IDLE) && grant_hit_s) begin
            ch_req_ready_s[grant_idx_s] = 1'b1;
        end else begin
            ch_req_ready_s = {NCH{1'b0}};
        end
    end

    // Beat-completion conditions and the pointer value following the current grant.
    always_comb begin
        ph0_done_s = bus.core_req_ready & bus.core_rsp_valid & bus.dn_rsp_ready;
        ph1_done_s = bus.core_rsp_valid & bus.dn_rsp_ready;
        if (grant_ch_r == 2'(NCH - 1)) begin
            rr_next_s = 2'd0;
        end else begin
            rr_next_s = grant_ch_r + 2'd1;
        end
    end

    // Window FSM with its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= 2'd0;
            grant_ch_r <= 2'd0;
            win_r      <= {WIN_W{1'b0}};
            win_cnt_r  <= 16'h0000;
            busy_r     <= 1'b0;
            phase_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_hit_s) begin
                        state_r    <= ST_PH0;
                        grant_ch_r <= grant_idx_s;
                        win_r      <= grant_pix_s;
                        busy_r     <= 1'b1;
                        phase_r    <= 1'b0;
                    end
                end
                ST_PH0: begin
                    if (ph0_done_s) begin
                        state_r <= ST_PH1;
                        phase_r <= 1'b1;
                    end
                end
                ST_PH1: begin
                    if (ph1_done_s) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        phase_r   <= 1'b0;
                        rr_ptr_r  <= rr_next_s;
                        win_cnt_r <= win_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    phase_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ch_req_ready  = ch_req_ready_s;
    assign bus.arb_req_valid = busy_r;
    assign bus.arb_pixels    = win_r;
    assign bus.arb_rsp_valid = bus.core_rsp_valid & busy_r;
    assign bus.arb_rsp_ready = bus.dn_rsp_ready & busy_r;
    assign bus.arb_rsp_data  = bus.core_rsp_data;
    assign bus.arb_rsp_ch    = grant_ch_r;
    assign bus.arb_rsp_phase = phase_r;
    assign bus.win_cnt       = win_cnt_r;
endmodule

// File: tb/tb_bicubic_channel_arbiter.sv
// Self-checking bench: grant table, round robin, stall, mid-window reset and counter wrap;
// result beats are checked against a queue of expected {channel, phase, data}.
module tb_bicubic_channel_arbiter;
    localparam int NCH    = 3;
    localparam int CW     = 8;
    localparam int WIN_W  = 16 * CW;
    localparam int BEAT_W = 8 * CW;

    typedef struct packed {
        logic [1:0]        ch;
        logic              phase;
        logic [BEAT_W-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [NCH-1:0] valid;
        logic [NCH-1:0] exp_ready;
        logic [1:0]     exp_ch;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    int               n_tests = 0;
    int               n_fail  = 0;
    beat_t            exp_q[$];
    logic [WIN_W-1:0] pix[NCH];
    logic [15:0]      exp_cnt;
    vec_t             tbl[8];

    bicubic_channel_arbiter_if #(.NCH(NCH), .CHANNEL_WIDTH(CW)) bus ();

    bicubic_channel_arbiter #(.NCH(NCH), .CHANNEL_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Core stand-in: returns the lower half of the window on beat 0, upper half on beat 1.
    assign bus.core_rsp_data = bus.arb_rsp_phase ? bus.arb_pixels[WIN_W-1:BEAT_W]
                                                 : bus.arb_pixels[BEAT_W-1:0];

    function automatic void check(input string name, input logic [WIN_W-1:0] act,
                                  input logic [WIN_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [WIN_W-1:0] ramp(input logic [7:0] base);
        logic [WIN_W-1:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = base + 8'(i);
        return r;
    endfunction

    // Scoreboard: every beat the DUT hands downstream must match the queue head.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n && bus.arb_rsp_valid && bus.arb_rsp_ready &&
            (bus.arb_rsp_phase || bus.core_req_ready)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 128'(1), 128'(0));
            end else begin
                b = exp_q.pop_front();
                check("beat_ch",    128'(bus.arb_rsp_ch),    128'(b.ch));
                check("beat_phase", 128'(bus.arb_rsp_phase), 128'(b.phase));
                check("beat_data",  128'(bus.arb_rsp_data),  128'(b.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix();
        for (int k = 0; k < NCH; k++) bus.ch_req_pixels[k*WIN_W +: WIN_W] = pix[k];
    endtask

    task automatic push_beats(input logic [1:0] ch, input logic both);
        exp_q.push_back('{ch: ch, phase: 1'b0, data: pix[ch][BEAT_W-1:0]});
        if (both) exp_q.push_back('{ch: ch, phase: 1'b1, data: pix[ch][WIN_W-1:BEAT_W]});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},     128'(bus.ch_req_ready),  128'(0));
        check({tag, "_req_valid"}, 128'(bus.arb_req_valid), 128'(0));
        check({tag, "_rsp_valid"}, 128'(bus.arb_rsp_valid), 128'(0));
        check({tag, "_rsp_ready"}, 128'(bus.arb_rsp_ready), 128'(0));
        check({tag, "_phase"},     128'(bus.arb_rsp_phase), 128'(0));
        check({tag, "_ch"},        128'(bus.arb_rsp_ch),    128'(0));
        check({tag, "_pixels"},    bus.arb_pixels,          128'(0));
        check({tag, "_win_cnt"},   128'(bus.win_cnt),       128'(0));
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (bus.arb_req_valid && k < 20) begin
            step();
            k++;
        end
        check(name, 128'(bus.arb_req_valid), 128'(0));
    endtask

    // Full window from an IDLE cycle: grant, PH0, PH1, back to IDLE.
    task automatic run_window(input logic [NCH-1:0] valid, input logic [NCH-1:0] exp_ready,
                              input logic [1:0] exp_ch);
        bus.ch_req_valid = valid;
        drive_pix();
        #1;
        check("grant_ready", 128'(bus.ch_req_ready), 128'(exp_ready));
        check("idle_req_valid", 128'(bus.arb_req_valid), 128'(0));
        push_beats(exp_ch, 1'b1);
        step();
        bus.ch_req_valid = '0;
        #1;
        check("ph0_req_valid", 128'(bus.arb_req_valid), 128'(1));
        check("ph0_pixels", bus.arb_pixels, pix[exp_ch]);
        check("ph0_ch", 128'(bus.arb_rsp_ch), 128'(exp_ch));
        check("ph0_ready_low", 128'(bus.ch_req_ready), 128'(0));
        wait_idle("window_done");
        exp_cnt = exp_cnt + 16'd1;
        check("win_cnt", 128'(bus.win_cnt), 128'(exp_cnt));
        check("beats_drained", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        logic [1:0]     rr_m;
        logic [NCH-1:0] oh;

        tbl[0] = '{valid: 3'b000, exp_ready: 3'b000, exp_ch: 2'd0};
        tbl[1] = '{valid: 3'b010, exp_ready: 3'b010, exp_ch: 2'd1};
        tbl[2] = '{valid: 3'b011, exp_ready: 3'b001, exp_ch: 2'd0};
        tbl[3] = '{valid: 3'b101, exp_ready: 3'b100, exp_ch: 2'd2};
        tbl[4] = '{valid: 3'b110, exp_ready: 3'b010, exp_ch: 2'd1};
        tbl[5] = '{valid: 3'b111, exp_ready: 3'b100, exp_ch: 2'd2};
        tbl[6] = '{valid: 3'b100, exp_ready: 3'b100, exp_ch: 2'd2};
        tbl[7] = '{valid: 3'b001, exp_ready: 3'b001, exp_ch: 2'd0};

        // Reset with requests pending and the core signalling valid.
        rst_n              = 1'b0;
        bus.ch_req_valid   = 3'b111;
        bus.core_req_ready = 1'b1;
        bus.core_rsp_valid = 1'b1;
        bus.dn_rsp_ready   = 1'b1;
        for (int k = 0; k < NCH; k++) pix[k] = ramp(8'(8'h30 + 8'(k * 8'h20)));
        drive_pix();
        exp_cnt = 16'h0000;
        #2;
        check_all_zero("reset");
        step();
        bus.ch_req_valid = '0;
        rst_n = 1'b1;
        #1;
        check("post_reset_req_valid", 128'(bus.arb_req_valid), 128'(0));

        // Grant table; rr pointer walks 0 -> 2 -> 1 -> 0 -> 2 -> 0 -> 0 -> 1.
        for (int e = 0; e < 8; e++) begin
            for (int k = 0; k < NCH; k++) pix[k] = ramp(8'(32 * e + 64 * k + 5));
            if (e == 1) pix[1] = ramp(8'h01);
            if (tbl[e].exp_ready == '0) begin
                bus.ch_req_valid = tbl[e].valid;
                #1;
                check("no_req_ready", 128'(bus.ch_req_ready), 128'(0));
                step();
                check("no_req_idle", 128'(bus.arb_req_valid), 128'(0));
            end else begin
                run_window(tbl[e].valid, tbl[e].exp_ready, tbl[e].exp_ch);
            end
        end

        // Downstream stall in PH1 while ch0 pixels change underneath.
        pix[0] = ramp(8'hA0);
        bus.ch_req_valid = 3'b001;
        drive_pix();
        #1;
        check("stall_grant", 128'(bus.ch_req_ready), 128'(3'b001));
        push_beats(2'd0, 1'b1);
        step();
        bus.ch_req_valid = '0;
        bus.ch_req_pixels[WIN_W-1:0] = ~pix[0];
        #1;
        check("iso_ph0_pixels", bus.arb_pixels, pix[0]);
        step();
        bus.dn_rsp_ready = 1'b0;
        bus.ch_req_pixels[WIN_W-1:0] = ramp(8'h11);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_phase", 128'(bus.arb_rsp_phase), 128'(1));
            check("stall_busy", 128'(bus.arb_req_valid), 128'(1));
            check("stall_pixels", bus.arb_pixels, pix[0]);
            check("stall_ch", 128'(bus.arb_rsp_ch), 128'(0));
            check("stall_rsp_ready", 128'(bus.arb_rsp_ready), 128'(0));
            @(posedge clk);
        end
        #1;
        bus.dn_rsp_ready = 1'b1;
        #1;
        check("stall_still_ph1", 128'(bus.arb_rsp_phase), 128'(1));
        step();
        check("stall_exit", 128'(bus.arb_req_valid), 128'(0));
        exp_cnt = exp_cnt + 16'd1;
        check("stall_win_cnt", 128'(bus.win_cnt), 128'(exp_cnt));
        check("stall_drained", 128'(exp_q.size()), 128'(0));

        // Reset asserted in PH1: second beat never appears, count restarts.
        for (int k = 0; k < NCH; k++) pix[k] = ramp(8'(8'h50 + 8'(k * 8'h10)));
        bus.ch_req_valid = 3'b010;
        drive_pix();
        #1;
        check("rst_grant", 128'(bus.ch_req_ready), 128'(3'b010));
        push_beats(2'd1, 1'b0);
        step();
        bus.ch_req_valid = '0;
        step();
        check("rst_in_ph1", 128'(bus.arb_rsp_phase), 128'(1));
        rst_n = 1'b0;
        bus.ch_req_valid = 3'b100;
        #1;
        check_all_zero("midrst");
        exp_cnt = 16'h0000;
        step();
        rst_n = 1'b1;
        #1;
        check("midrst_drained", 128'(exp_q.size()), 128'(0));
        run_window(3'b100, 3'b100, 2'd2);

        // All channels continuously valid: grants 0,1,2,0,1,2 with one bubble each.
        for (int k = 0; k < NCH; k++) pix[k] = ramp(8'(8'h90 + 8'(k * 8'h18)));
        drive_pix();
        bus.ch_req_valid = 3'b111;
        rr_m = 2'd0;
        for (int w = 0; w < 6; w++) begin
            #1;
            oh = 3'b001 << rr_m;
            check("rr_grant", 128'(bus.ch_req_ready), 128'(oh));
            check("rr_bubble", 128'(bus.arb_req_valid), 128'(0));
            push_beats(rr_m, 1'b1);
            step();
            check("rr_ph0", 128'({bus.arb_req_valid, bus.arb_rsp_phase}), 128'(2'b10));
            check("rr_ch", 128'(bus.arb_rsp_ch), 128'(rr_m));
            step();
            check("rr_ph1", 128'({bus.arb_req_valid, bus.arb_rsp_phase}), 128'(2'b11));
            step();
            rr_m = (rr_m == 2'd2) ? 2'd0 : rr_m + 2'd1;
            exp_cnt = exp_cnt + 16'd1;
        end
        bus.ch_req_valid = '0;
        check("rr_win_cnt", 128'(bus.win_cnt), 128'(exp_cnt));
        check("rr_drained", 128'(exp_q.size()), 128'(0));

        // Counter wrap from 0xFFFF.
        step();
        force dut.win_cnt_r = 16'hFFFF;
        #1;
        release dut.win_cnt_r;
        exp_cnt = 16'hFFFF;
        pix[1] = ramp(8'hE0);
        run_window(3'b010, 3'b010, 2'd1);
        check("wrap_zero", 128'(bus.win_cnt), 128'(16'h0000));

        step();
        check("final_drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bicubic_channel_arbiter.md
BICUBIC_CHANNEL_ARBITER -- requirements
Module: bicubic_channel_arbiter

Interface
REQ-001 Parameter: NCH, 3, number of requesting colour channels (2..4).
REQ-002 Parameter: CHANNEL_WIDTH, 8, bits per pixel sample.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: ch_req_valid  input  NCH  per-channel window request.
REQ-006 Port: ch_req_ready  output  NCH  per-channel accept; one-hot or zero.
REQ-007 Port: ch_req_pixels  input  NCH*16*CHANNEL_WIDTH  per-channel 4x4 window; channel k occupies slice k, p1 in the LSBs.
REQ-008 Port: arb_req_valid  output  1  window valid towards the upsample core.
REQ-009 Port: core_req_ready  input  1  core accepts a window (core phase 0 only).
REQ-010 Port: arb_pixels  output  16*CHANNEL_WIDTH  registered window driven to the core.
REQ-011 Port: core_rsp_valid  input  1  core result beat valid.
REQ-012 Port: core_rsp_data  input  8*CHANNEL_WIDTH  core result beat (8 samples).
REQ-013 Port: arb_rsp_ready  output  1  ready towards the core.
REQ-014 Port: arb_rsp_valid  output  1  result beat valid downstream.
REQ-015 Port: arb_rsp_data  output  8*CHANNEL_WIDTH  result beat, equal to core_rsp_data.
REQ-016 Port: arb_rsp_ch  output  2  channel index owning the beat.
REQ-017 Port: arb_rsp_phase  output  1  0 = first beat (rows 1/2), 1 = second beat (rows 3/4).
REQ-018 Port: dn_rsp_ready  input  1  downstream ready.
REQ-019 Port: win_cnt  output  16  completed windows since reset, wrapping.

Function
REQ-020 FSM states IDLE, PH0, PH1; encoding free.
REQ-021 IDLE: if any ch_req_valid, grant the lowest-index valid channel at or after rr_ptr (cyclic), pulse ch_req_ready for that channel for one cycle, latch its pixels into the window register and its index into grant_ch, then go to PH0.
REQ-022 IDLE with no valid request: remain IDLE; ch_req_ready = 0.
REQ-023 ch_req_ready is asserted only in IDLE, and only for the granted channel.
REQ-024 arb_req_valid = 1 in PH0 and PH1, and 0 in IDLE.
REQ-025 arb_pixels = window register, stable from PH0 entry through PH1 exit.
REQ-026 arb_rsp_valid = core_rsp_valid & (state is PH0 or PH1).
REQ-027 arb_rsp_ready = dn_rsp_ready & (state is PH0 or PH1).
REQ-028 arb_rsp_data = core_rsp_data, combinational pass-through.
REQ-029 arb_rsp_ch = grant_ch; arb_rsp_phase = 1 exactly in PH1.
REQ-030 PH0 -> PH1 when core_req_ready & core_rsp_valid & dn_rsp_ready in the same cycle; otherwise hold PH0.
REQ-031 PH1 -> IDLE when core_rsp_valid & dn_rsp_ready; on that edge: rr_ptr = (grant_ch+1) mod NCH, win_cnt += 1 (wraps 0xFFFF -> 0x0000).
REQ-032 Back-to-back windows have one IDLE bubble cycle; latency from ch_req_valid to first beat is 1 cycle (grant edge) plus core latency.
REQ-033 ch_req_valid deassertion while not in IDLE has no effect on the current window.
REQ-034 Downstream stall (dn_rsp_ready = 0) holds state, grant and window register unchanged.
REQ-035 ch_req_pixels of non-granted channels are never sampled.

Reset
REQ-036 Asserting rst_n low at any time (including mid PH0/PH1) forces IDLE, rr_ptr = 0, grant_ch = 0, window register = 0 and win_cnt = 0; the in-flight window is discarded without completion.
REQ-037 During reset, all outputs are 0: ch_req_ready, arb_req_valid, arb_rsp_valid, arb_rsp_ready, arb_rsp_phase, arb_rsp_ch, arb_pixels and win_cnt.

Verification
REQ-038 Single request: ch1 valid with pixels 0x01..0x10, core always ready and valid -> ch_req_ready = 3'b010 for 1 cycle, then beats with phase 0 then phase 1, arb_rsp_ch = 1, win_cnt = 1.
REQ-039 Round robin: all 3 channels continuously valid -> grant order 0,1,2,0,1,2; each window yields 2 beats; 1 idle cycle between windows.
REQ-040 Downstream stall: dn_rsp_ready = 0 for 5 cycles in PH1 -> state, arb_pixels and arb_rsp_ch stay unchanged; the exit occurs on the first cycle with ready = 1.
REQ-041 Reset mid-window: rst_n low in PH1 -> all outputs 0 immediately; after release, a ch2 request is granted first (rr_ptr = 0, ch0 and ch1 idle) and win_cnt restarts from 1.
REQ-042 Counter wrap: preload 0xFFFF windows via force -> the next completion gives win_cnt = 0x0000.
REQ-043 Pixel isolation: change ch0 pixels during PH0/PH1 -> arb_pixels stays unchanged.
